// File: rtl/pc_shot_engine_if.sv
// Signal bundle between the PC shot engine, the game FSM (turn control) and
// the player board register array (single-cell read/write port).
interface pc_shot_engine_if;
  // Handshake rules:
  // - turn_start is a one-cycle request. It is accepted only while the engine
  //   is idle. busy rises in the next cycle and stays high until the cycle in
  //   which shot_valid pulses.
  // - shot_valid is a one-cycle result strobe and needs no ready. shot_i,
  //   shot_j, shot_hit and no_target hold their values until the next
  //   shot_valid.
  // - cell_rd_data is a combinational read of (cell_i, cell_j).
  // - cell_wr_en writes cell_wr_data to (cell_i, cell_j) at the next clock edge.
  logic       turn_start;
  logic       seed_load;
  logic [7:0] seed_value;
  logic [3:0] ship_cells_total;
  logic [2:0] cell_i;
  logic [2:0] cell_j;
  logic [1:0] cell_rd_data;
  logic       cell_wr_en;
  logic [1:0] cell_wr_data;
  logic       busy;
  logic       shot_valid;
  logic [2:0] shot_i;
  logic [2:0] shot_j;
  logic       shot_hit;
  logic       no_target;
  logic [3:0] hit_count;
  logic       is_defeat;
  logic [2:0] dbg_state;

  modport master (
    input  turn_start, seed_load, seed_value, ship_cells_total, cell_rd_data,
    output cell_i, cell_j, cell_wr_en, cell_wr_data, busy, shot_valid,
           shot_i, shot_j, shot_hit, no_target, hit_count, is_defeat, dbg_state
  );

  modport slave (
    output turn_start, seed_load, seed_value, ship_cells_total, cell_rd_data,
    input  cell_i, cell_j, cell_wr_en, cell_wr_data, busy, shot_valid,
           shot_i, shot_j, shot_hit, no_target, hit_count, is_defeat, dbg_state
  );
endinterface

// File: rtl/pc_shot_engine.sv
// PC firing engine: after a visible think delay it picks an unfired player cell
// (random LFSR tries, then a row-major scan), marks it hit or miss and reports.
module pc_shot_engine #(
  parameter int         BOARD_N      = 5,
  parameter int         THINK_CYCLES = 16,
  parameter int         MAX_TRIES    = 32,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  pc_shot_engine_if.master bus
);

  localparam int         TW   = $clog2(THINK_CYCLES + 1);
  localparam int         RW   = $clog2(MAX_TRIES + 1);
  localparam logic [2:0] LAST = 3'(BOARD_N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_THINK  = 3'd1,
    S_PICK   = 3'd2,
    S_SCAN   = 3'd3,
    S_WRITE  = 3'd4,
    S_REPORT = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [TW-1:0] think_q, think_d;
  logic [RW-1:0] tries_q, tries_d;
  logic [2:0]    scan_i_q, scan_i_d;
  logic [2:0]    scan_j_q, scan_j_d;
  logic [2:0]    tgt_i_q, tgt_i_d;
  logic [2:0]    tgt_j_q, tgt_j_d;
  logic          tgt_hit_q, tgt_hit_d;
  logic [3:0]    total_q, total_d;
  logic [3:0]    hit_q, hit_d;
  logic          defeat_q, defeat_d;
  logic [2:0]    shot_i_q, shot_i_d;
  logic [2:0]    shot_j_q, shot_j_d;
  logic          shot_hit_q, shot_hit_d;
  logic          no_target_q, no_target_d;

  logic [2:0]    cand_i, cand_j;
  logic          cand_ok;
  logic [2:0]    cell_i_c, cell_j_c;
  logic          wr_en_c;
  logic [1:0]    wr_data_c;

  assign cand_i  = lfsr_q[2:0];
  assign cand_j  = lfsr_q[5:3];
  assign cand_ok = (int'(cand_i) < BOARD_N) && (int'(cand_j) < BOARD_N);

  // Fibonacci LFSR, taps 8,6,5,4; frozen in IDLE so a seed load is exact.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (state_q == S_IDLE) begin
      lfsr_d = lfsr_q;
      if (bus.seed_load) begin
        lfsr_d = (bus.seed_value == 8'd0) ? LFSR_SEED : bus.seed_value;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    think_d     = think_q;
    tries_d     = tries_q;
    scan_i_d    = scan_i_q;
    scan_j_d    = scan_j_q;
    tgt_i_d     = tgt_i_q;
    tgt_j_d     = tgt_j_q;
    tgt_hit_d   = tgt_hit_q;
    total_d     = total_q;
    hit_d       = hit_q;
    defeat_d    = defeat_q;
    shot_i_d    = shot_i_q;
    shot_j_d    = shot_j_q;
    shot_hit_d  = shot_hit_q;
    no_target_d = no_target_q;
    cell_i_c    = 3'd0;
    cell_j_c    = 3'd0;
    wr_en_c     = 1'b0;
    wr_data_c   = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        if (bus.turn_start) begin
          state_d = S_THINK;
          think_d = TW'(THINK_CYCLES);
          total_d = bus.ship_cells_total;
          tries_d = '0;
        end
      end

      S_THINK: begin
        think_d = think_q - TW'(1);
        if (think_q <= TW'(1)) state_d = S_PICK;
      end

      S_PICK: begin
        cell_i_c = cand_i;
        cell_j_c = cand_j;
        if (cand_ok && !bus.cell_rd_data[1]) begin
          tgt_i_d   = cand_i;
          tgt_j_d   = cand_j;
          tgt_hit_d = bus.cell_rd_data[0];
          state_d   = S_WRITE;
        end else begin
          tries_d = tries_q + RW'(1);
          if (tries_q == RW'(MAX_TRIES - 1)) begin
            state_d  = S_SCAN;
            scan_i_d = 3'd0;
            scan_j_d = 3'd0;
          end
        end
      end

      S_SCAN: begin
        cell_i_c = scan_i_q;
        cell_j_c = scan_j_q;
        if (!bus.cell_rd_data[1]) begin
          tgt_i_d   = scan_i_q;
          tgt_j_d   = scan_j_q;
          tgt_hit_d = bus.cell_rd_data[0];
          state_d   = S_WRITE;
        end else if (scan_i_q == LAST && scan_j_q == LAST) begin
          // Every cell already fired: report (0,0) as a miss with no_target.
          state_d     = S_REPORT;
          shot_i_d    = 3'd0;
          shot_j_d    = 3'd0;
          shot_hit_d  = 1'b0;
          no_target_d = 1'b1;
        end else if (scan_j_q == LAST) begin
          scan_i_d = scan_i_q + 3'd1;
          scan_j_d = 3'd0;
        end else begin
          scan_j_d = scan_j_q + 3'd1;
        end
      end

      S_WRITE: begin
        cell_i_c    = tgt_i_q;
        cell_j_c    = tgt_j_q;
        wr_en_c     = 1'b1;
        wr_data_c   = tgt_hit_q ? 2'b11 : 2'b10;
        if (tgt_hit_q && hit_q != 4'hF) hit_d = hit_q + 4'd1;
        state_d     = S_REPORT;
        shot_i_d    = tgt_i_q;
        shot_j_d    = tgt_j_q;
        shot_hit_d  = tgt_hit_q;
        no_target_d = 1'b0;
      end

      S_REPORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Defeat is judged on the updated hit count as the report is entered.
    if (state_q != S_REPORT && state_d == S_REPORT &&
        total_q != 4'd0 && hit_d == total_q) begin
      defeat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      think_q     <= '0;
      tries_q     <= '0;
      scan_i_q    <= 3'd0;
      scan_j_q    <= 3'd0;
      tgt_i_q     <= 3'd0;
      tgt_j_q     <= 3'd0;
      tgt_hit_q   <= 1'b0;
      total_q     <= 4'd0;
      hit_q       <= 4'd0;
      defeat_q    <= 1'b0;
      shot_i_q    <= 3'd0;
      shot_j_q    <= 3'd0;
      shot_hit_q  <= 1'b0;
      no_target_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      think_q     <= think_d;
      tries_q     <= tries_d;
      scan_i_q    <= scan_i_d;
      scan_j_q    <= scan_j_d;
      tgt_i_q     <= tgt_i_d;
      tgt_j_q     <= tgt_j_d;
      tgt_hit_q   <= tgt_hit_d;
      total_q     <= total_d;
      hit_q       <= hit_d;
      defeat_q    <= defeat_d;
      shot_i_q    <= shot_i_d;
      shot_j_q    <= shot_j_d;
      shot_hit_q  <= shot_hit_d;
      no_target_q <= no_target_d;
    end
  end

  assign bus.cell_i       = cell_i_c;
  assign bus.cell_j       = cell_j_c;
  assign bus.cell_wr_en   = wr_en_c;
  assign bus.cell_wr_data = wr_data_c;
  assign bus.busy         = (state_q == S_THINK) || (state_q == S_PICK) ||
                            (state_q == S_SCAN)  || (state_q == S_WRITE);
  assign bus.shot_valid   = (state_q == S_REPORT);
  assign bus.shot_i       = shot_i_q;
  assign bus.shot_j       = shot_j_q;
  assign bus.shot_hit     = shot_hit_q;
  assign bus.no_target    = no_target_q;
  assign bus.hit_count    = hit_q;
  assign bus.is_defeat    = defeat_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_pc_shot_engine.sv
// Bench for pc_shot_engine: emulated player board, turn-level reference model,
// scoreboard queues for shot results and cell writes.
module tb_pc_shot_engine;
  localparam int         N    = 5;
  localparam int         T    = 2;
  localparam int         MT   = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_shot_engine_if bif();

  pc_shot_engine #(
    .BOARD_N(N), .THINK_CYCLES(T), .MAX_TRIES(MT), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  int errors = 0;
  int checks = 0;

  logic [1:0] board  [N][N];
  logic [1:0] mboard [N][N];
  logic [7:0] m_lfsr;
  logic [3:0] m_hits;
  logic       m_defeat;

  // {no_target, shot_hit, shot_i, shot_j, hit_count, is_defeat}
  logic [12:0] shot_q[$];
  // {cell_i, cell_j, cell_wr_data}
  logic [7:0]  wr_q[$];

  always_comb begin
    bif.cell_rd_data = 2'b00;
    if (int'(bif.cell_i) < N && int'(bif.cell_j) < N)
      bif.cell_rd_data = board[int'(bif.cell_i)][int'(bif.cell_j)];
  end

  function automatic logic [7:0] adv(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // One whole turn: T think cycles, then random tries, then a scan, then the
  // write and report cycles; the LFSR steps once per non-idle cycle.
  task automatic predict(input logic [3:0] total, output int lat,
                         output logic [12:0] sexp, output bit wr,
                         output logic [7:0] wexp);
    int picks = 0, scans = 0, fi = 0, fj = 0;
    bit found = 0, hit = 0;
    for (int k = 0; k < T; k++) m_lfsr = adv(m_lfsr);
    while (!found && picks < MT) begin
      int ci = int'(m_lfsr[2:0]);
      int cj = int'(m_lfsr[5:3]);
      picks++;
      if (ci < N && cj < N && !mboard[ci][cj][1]) begin
        found = 1; fi = ci; fj = cj;
      end
      m_lfsr = adv(m_lfsr);
    end
    for (int k = 0; k < N * N && !found; k++) begin
      scans++;
      if (!mboard[k / N][k % N][1]) begin
        found = 1; fi = k / N; fj = k % N;
      end
      m_lfsr = adv(m_lfsr);
    end
    wr = found;
    wexp = 8'h00;
    if (found) begin
      hit = (mboard[fi][fj] == 2'b01);
      mboard[fi][fj] = hit ? 2'b11 : 2'b10;
      if (hit && m_hits != 4'hF) m_hits = m_hits + 4'd1;
      wexp = {3'(fi), 3'(fj), hit ? 2'b11 : 2'b10};
      m_lfsr = adv(m_lfsr);
    end
    m_lfsr = adv(m_lfsr);
    if (total != 0 && m_hits == total) m_defeat = 1'b1;
    lat  = T + picks + scans + (found ? 2 : 1);
    sexp = {!found, hit, 3'(fi), 3'(fj), m_hits, m_defeat};
  endtask

  function automatic logic [7:0] find_seed(input int ti, input int tj);
    logic [7:0] v;
    for (int s = 1; s < 256; s++) begin
      v = 8'(s);
      for (int k = 0; k < T; k++) v = adv(v);
      if (int'(v[2:0]) == ti && int'(v[5:3]) == tj) return 8'(s);
    end
    return 8'h01;
  endfunction

  task automatic fill_board(input int mode);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int r = $urandom_range(0, 9);
        logic [1:0] v;
        case (mode)
          0: v = 2'b00;
          1: v = 2'b10;
          2: v = 2'b11;
          default: v = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
        endcase
        board[i][j]  = v;
        mboard[i][j] = v;
      end
    end
  endtask

  task automatic set_cell(input int i, input int j, input logic [1:0] v);
    board[i][j]  = v;
    mboard[i][j] = v;
  endtask

  task automatic check_idle_zero(input string name);
    logic [27:0] act;
    act = {bif.busy, bif.shot_valid, bif.cell_wr_en, bif.cell_wr_data,
           bif.cell_i, bif.cell_j, bif.shot_i, bif.shot_j, bif.shot_hit,
           bif.no_target, bif.hit_count, bif.is_defeat, 4'h0};
    checks++;
    if (act !== 28'd0) begin
      errors++;
      $display("FAIL %s outputs=%h required=0", name, act);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = SEED; m_hits = 4'd0; m_defeat = 1'b0;
    @(negedge clk);
    check_idle_zero("reset_state");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_turn(input logic [3:0] total, input bit ld,
                          input logic [7:0] sv, input bit disturb);
    int lat, cyc;
    bit wr, seen;
    logic [12:0] sexp;
    logic [7:0] wexp;
    @(negedge clk);
    bif.turn_start = 1'b1;
    bif.seed_load = ld;
    bif.seed_value = sv;
    bif.ship_cells_total = total;
    if (ld) m_lfsr = (sv == 8'd0) ? SEED : sv;
    predict(total, lat, sexp, wr, wexp);
    shot_q.push_back(sexp);
    if (wr) wr_q.push_back(wexp);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      bif.turn_start = 1'b0;
      bif.seed_load = 1'b0;
      cyc++;
      if (disturb && cyc == 1) begin
        bif.turn_start = 1'b1;
        bif.seed_load = 1'b1;
        bif.seed_value = 8'h00;
      end
      if (bif.cell_wr_en && int'(bif.cell_i) < N && int'(bif.cell_j) < N)
        board[int'(bif.cell_i)][int'(bif.cell_j)] = bif.cell_wr_data;
      if (bif.shot_valid) begin
        seen = 1;
        checks++;
        if (bif.busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_report got=%b required=0", bif.busy);
        end
      end else begin
        checks++;
        if (bif.busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_in_turn cycle=%0d got=%b required=1", cyc, bif.busy);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL shot_timeout waited=%0d cycles required=%0d", cyc, lat);
    end else if (cyc != lat) begin
      errors++;
      $display("FAIL latency got=%0d required=%0d", cyc, lat);
    end
  endtask

  task automatic abort_turn();
    @(negedge clk);
    bif.turn_start = 1'b1;
    bif.ship_cells_total = 4'd3;
    @(negedge clk);
    bif.turn_start = 1'b0;
    checks++;
    if (bif.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_abort got=%b required=1", bif.busy);
    end
    #1 rst = 1'b0;
    m_lfsr = SEED; m_hits = 4'd0; m_defeat = 1'b0;
    #1 check_idle_zero("abort_immediate");
    @(negedge clk);
    check_idle_zero("abort_held");
    rst = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    logic [12:0] s_act, s_exp;
    logic [7:0]  w_act, w_exp;
    if (rst) begin
      if (bif.shot_valid) begin
        s_act = {bif.no_target, bif.shot_hit, bif.shot_i, bif.shot_j,
                 bif.hit_count, bif.is_defeat};
        checks++;
        if (shot_q.size() == 0) begin
          errors++;
          $display("FAIL shot_unexpected got=%h required=none", s_act);
        end else begin
          s_exp = shot_q.pop_front();
          if (s_act !== s_exp) begin
            errors++;
            $display("FAIL shot_result got=%h required=%h", s_act, s_exp);
          end
        end
      end
      if (bif.cell_wr_en) begin
        w_act = {bif.cell_i, bif.cell_j, bif.cell_wr_data};
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected got=%h required=none", w_act);
        end else begin
          w_exp = wr_q.pop_front();
          if (w_act !== w_exp) begin
            errors++;
            $display("FAIL cell_write got=%h required=%h", w_act, w_exp);
          end
        end
      end
    end
  end

  initial begin
    bif.turn_start = 1'b0;
    bif.seed_load = 1'b0;
    bif.seed_value = 8'h00;
    bif.ship_cells_total = 4'd0;
    fill_board(0);
    m_lfsr = SEED; m_hits = 4'd0; m_defeat = 1'b0;

    // Fresh reset, empty board, default seed.
    do_reset();
    run_turn(4'd0, 1'b0, 8'h00, 1'b0);

    // Single ship, seed chosen to land on it; then a further miss turn.
    do_reset();
    fill_board(0);
    set_cell(2, 3, 2'b01);
    run_turn(4'd1, 1'b1, find_seed(2, 3), 1'b0);
    run_turn(4'd1, 1'b0, 8'h00, 1'b0);

    // Only (4,4) unfired: the scan has to find it.
    do_reset();
    fill_board(1);
    set_cell(4, 4, 2'b00);
    run_turn(4'd0, 1'b0, 8'h00, 1'b0);

    // Fully fired board: no target, no write.
    fill_board(2);
    run_turn(4'd4, 1'b0, 8'h00, 1'b0);

    // Second turn_start and a zero seed load while busy are both ignored.
    do_reset();
    fill_board(0);
    run_turn(4'd2, 1'b1, 8'h3C, 1'b1);
    run_turn(4'd2, 1'b0, 8'h00, 1'b0);

    // Reset in THINK, then a fresh turn on an empty board.
    fill_board(0);
    abort_turn();
    run_turn(4'd0, 1'b0, 8'h00, 1'b0);

    // Random boards, ship totals and seed loads.
    do_reset();
    for (int t = 0; t < 40; t++) begin
      bit ld;
      logic [7:0] sv;
      if (t % 5 == 0) fill_board(3);
      ld = ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      run_turn(4'($urandom_range(0, 15)), ld, sv, 1'b0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (shot_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations shots=%0d writes=%0d required=0",
               shot_q.size(), wr_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
